mem_port_arbiter: RTL and testbench

//   Shares the single external memory port between the instruction cache
//   (fill on miss/uncached fetch) and the data cache (fill, write-through,

---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between I-cache and D-cache requests.
// D side wins arbitration; I side is forced through after MAX_D_STREAK consecutive D grants.
//
// state | meaning
// IDLE  | port free, arbitrate pending requests
// IBUSY | I-cache owns the port until m_ready or strobe drop
// DBUSY | D-cache owns the port until m_ready or strobe drop
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] i_a,
    input  logic        i_strobe,
    output logic [31:0] i_dout,
    output logic        i_ready,
    input  logic [31:0] d_a,
    input  logic [31:0] d_din,
    input  logic        d_rw,
    input  logic        d_strobe,
    output logic [31:0] d_dout,
    output logic        d_ready,
    output logic [31:0] m_a,
    output logic [31:0] m_din,
    output logic        m_rw,
    output logic        m_strobe,
    input  logic [31:0] m_dout,
    input  logic        m_ready,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] streak, streak_nxt;
    logic             starve;

    assign starve = i_strobe && (streak == STREAK_MAX);
    assign owner  = state;
    assign i_dout = m_dout;
    assign d_dout = m_dout;

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        m_a        = '0;
        m_din      = '0;
        m_rw       = 1'b0;
        m_strobe   = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (d_strobe && !starve) begin
                    state_nxt = DBUSY;
                    // streak only grows while the I side is actually waiting
                    if (!i_strobe)
                        streak_nxt = '0;
                    else if (streak < STREAK_MAX)
                        streak_nxt = streak + CNT_W'(1);
                end else if (i_strobe) begin
                    state_nxt  = IBUSY;
                    streak_nxt = '0;
                end
            end
            IBUSY: begin
                m_a      = i_a;
                m_strobe = i_strobe;
                if (!i_strobe) begin
                    state_nxt = IDLE;
                end else if (m_ready) begin
                    i_ready   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DBUSY: begin
                m_a      = d_a;
                m_din    = d_din;
                m_rw     = d_rw;
                m_strobe = d_strobe;
                if (!d_strobe) begin
                    state_nxt = IDLE;
                end else if (m_ready) begin
                    d_ready   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // reset must silence the port immediately, not one cycle later
        if (clr) begin
            m_strobe = 1'b0;
            i_ready  = 1'b0;
            d_ready  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single read, collision,
// I-side anti-starvation, abort and reset during a transaction.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] i_a;
    logic        i_strobe;
    logic [31:0] i_dout;
    logic        i_ready;
    logic [31:0] d_a;
    logic [31:0] d_din;
    logic        d_rw;
    logic        d_strobe;
    logic [31:0] d_dout;
    logic        d_ready;
    logic [31:0] m_a;
    logic [31:0] m_din;
    logic        m_rw;
    logic        m_strobe;
    logic [31:0] m_dout;
    logic        m_ready;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MAX_D_STREAK(4), .CNT_W(3)) dut (
        .clk(clk), .clr(clr),
        .i_a(i_a), .i_strobe(i_strobe), .i_dout(i_dout), .i_ready(i_ready),
        .d_a(d_a), .d_din(d_din), .d_rw(d_rw), .d_strobe(d_strobe),
        .d_dout(d_dout), .d_ready(d_ready),
        .m_a(m_a), .m_din(m_din), .m_rw(m_rw), .m_strobe(m_strobe),
        .m_dout(m_dout), .m_ready(m_ready), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        i_strobe = 1'b0;
        d_strobe = 1'b0;
        m_ready  = 1'b0;
        clr      = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        clr = 1'b1; i_strobe = 1'b1; d_strobe = 1'b1; m_ready = 1'b0;
        i_a = 32'h0000_0100; d_a = 32'hA000_0040; d_din = 32'h0; d_rw = 1'b0;
        m_dout = 32'h0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner cyc%0d got=%b exp=00", c, owner); end
            checks++; if (m_strobe !== 1'b0) begin errors++; $display("FAIL reset_mstrobe cyc%0d got=%b exp=0", c, m_strobe); end
        end
        clr = 1'b0;
        tick();
        checks++; if (owner !== 2'b10) begin errors++; $display("FAIL reset_release_owner got=%b exp=10", owner); end
        checks++; if (m_a !== 32'hA000_0040) begin errors++; $display("FAIL reset_release_ma got=%h exp=a0000040", m_a); end
        go_idle();
    endtask

    task automatic test_single_read;
        i_a = 32'h0000_0100; i_strobe = 1'b1; d_strobe = 1'b0;
        m_ready = 1'b1; m_dout = 32'h0;
        #1;
        checks++; if (i_ready !== 1'b0 || m_strobe !== 1'b0) begin errors++; $display("FAIL read_idle_ready got i_ready=%b m_strobe=%b exp=0 0", i_ready, m_strobe); end
        m_ready = 1'b0;
        tick();
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL read_owner got=%b exp=01", owner); end
        checks++; if (m_strobe !== 1'b1 || m_a !== 32'h0000_0100 || m_rw !== 1'b0) begin errors++; $display("FAIL read_port got strobe=%b a=%h rw=%b exp=1 00000100 0", m_strobe, m_a, m_rw); end
        tick();
        tick();
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL read_early_ready got=%b exp=0", i_ready); end
        m_ready = 1'b1; m_dout = 32'hDEAD_BEEF;
        #1;
        checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin errors++; $display("FAIL read_ready got i=%b d=%b exp=1 0", i_ready, d_ready); end
        checks++; if (i_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data got=%h exp=deadbeef", i_dout); end
        tick();
        i_strobe = 1'b0; m_ready = 1'b0;
        #1;
        checks++; if (owner !== 2'b00 || i_ready !== 1'b0) begin errors++; $display("FAIL read_done got owner=%b i_ready=%b exp=00 0", owner, i_ready); end
        go_idle();
    endtask

    task automatic test_collision;
        i_a = 32'h0000_0300; d_a = 32'h0000_0200; d_din = 32'h0000_1234; d_rw = 1'b1;
        i_strobe = 1'b1; d_strobe = 1'b1; m_ready = 1'b0;
        tick();
        checks++; if (owner !== 2'b10) begin errors++; $display("FAIL coll_owner_d got=%b exp=10", owner); end
        checks++; if (m_rw !== 1'b1 || m_din !== 32'h0000_1234 || m_a !== 32'h0000_0200) begin errors++; $display("FAIL coll_dport got rw=%b din=%h a=%h exp=1 00001234 00000200", m_rw, m_din, m_a); end
        m_ready = 1'b1;
        #1;
        checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin errors++; $display("FAIL coll_dready got d=%b i=%b exp=1 0", d_ready, i_ready); end
        tick();
        d_strobe = 1'b0; m_ready = 1'b0;
        #1;
        checks++; if (owner !== 2'b00 || m_strobe !== 1'b0 || m_a !== 32'h0) begin errors++; $display("FAIL coll_gap got owner=%b strobe=%b a=%h exp=00 0 0", owner, m_strobe, m_a); end
        tick();
        checks++; if (owner !== 2'b01 || m_a !== 32'h0000_0300 || m_rw !== 1'b0 || m_din !== 32'h0) begin errors++; $display("FAIL coll_iport got owner=%b a=%h rw=%b din=%h exp=01 00000300 0 0", owner, m_a, m_rw, m_din); end
        m_ready = 1'b1;
        #1;
        checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin errors++; $display("FAIL coll_iready got i=%b d=%b exp=1 0", i_ready, d_ready); end
        tick();
        i_strobe = 1'b0; m_ready = 1'b0;
        d_rw = 1'b0;
        #1;
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL coll_done got=%b exp=00", owner); end
        go_idle();
    endtask

    task automatic test_starvation;
        int  dgrants;
        bit  got_i;
        i_strobe = 1'b1; d_strobe = 1'b1; m_ready = 1'b1; d_rw = 1'b0;
        for (int round = 0; round < 2; round++) begin
            dgrants = 0;
            got_i   = 1'b0;
            for (int c = 0; c < 40 && !got_i; c++) begin
                tick();
                if (owner == 2'b10) dgrants++;
                if (owner == 2'b01) got_i = 1'b1;
            end
            checks++; if (!got_i) begin errors++; $display("FAIL starve_igrant round%0d got=none exp=granted within 40 cycles", round); end
            checks++; if (dgrants != 4) begin errors++; $display("FAIL starve_dcount round%0d got=%0d exp=4", round, dgrants); end
        end
        go_idle();
    endtask

    task automatic test_abort;
        i_a = 32'h0000_0500; d_a = 32'h0000_0600; d_rw = 1'b0;
        i_strobe = 1'b1; d_strobe = 1'b1; m_ready = 1'b0;
        tick();
        checks++; if (owner !== 2'b10) begin errors++; $display("FAIL abort_dgrant got=%b exp=10", owner); end
        d_strobe = 1'b0; m_ready = 1'b1;
        #1;
        checks++; if (m_strobe !== 1'b0 || d_ready !== 1'b0 || i_ready !== 1'b0) begin errors++; $display("FAIL abort_cycle got strobe=%b d_ready=%b i_ready=%b exp=0 0 0", m_strobe, d_ready, i_ready); end
        tick();
        m_ready = 1'b0;
        #1;
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL abort_idle got=%b exp=00", owner); end
        tick();
        checks++; if (owner !== 2'b01 || m_a !== 32'h0000_0500) begin errors++; $display("FAIL abort_igrant got owner=%b a=%h exp=01 00000500", owner, m_a); end
        go_idle();
    endtask

    task automatic test_reset_midop;
        i_a = 32'h0000_0700; i_strobe = 1'b1; d_strobe = 1'b0; m_ready = 1'b0;
        tick();
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL midrst_igrant got=%b exp=01", owner); end
        clr = 1'b1; m_ready = 1'b1;
        #1;
        checks++; if (m_strobe !== 1'b0 || i_ready !== 1'b0) begin errors++; $display("FAIL midrst_force got strobe=%b i_ready=%b exp=0 0", m_strobe, i_ready); end
        tick();
        clr = 1'b0; i_strobe = 1'b0; m_ready = 1'b0;
        #1;
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL midrst_owner got=%b exp=00", owner); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_collision();
        test_starvation();
        test_abort();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
